// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO registers.
// Results are computed at issue, held pending, and committed after a fixed busy window.
module muldiv_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        hiloUseD,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [31:0]     pend_hi, pend_lo;
  logic            pend_commit;
  logic            is_md;
  logic            div_zero;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        sden, uden;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  assign is_md    = (op >= OP_MULT) && (op <= OP_DIVU);
  assign div_zero = (srcB == 32'd0);

  assign prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  // The overflow case (-2^31 / -1) divides by 1 instead, which yields exactly the
  // architected q=0x80000000, r=0; a zero divisor also maps to 1 (result discarded).
  assign sden   = (div_zero || (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF)) ? 32'd1 : srcB;
  assign uden   = div_zero ? 32'd1 : srcB;
  assign quot_s = $signed(srcA) / $signed(sden);
  assign rem_s  = $signed(srcA) % $signed(sden);
  assign quot_u = srcA / uden;
  assign rem_u  = srcA % uden;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_hi     <= '0;
      pend_lo     <= '0;
      pend_commit <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {pend_hi, pend_lo} <= prod_s;
                pend_commit        <= 1'b1;
                cnt                <= CW'(MULT_CYCLES);
              end
              OP_MULTU: begin
                {pend_hi, pend_lo} <= prod_u;
                pend_commit        <= 1'b1;
                cnt                <= CW'(MULT_CYCLES);
              end
              OP_DIV: begin
                pend_hi     <= rem_s;
                pend_lo     <= quot_s;
                pend_commit <= !div_zero;
                cnt         <= CW'(DIV_CYCLES);
              end
              OP_DIVU: begin
                pend_hi     <= rem_u;
                pend_lo     <= quot_u;
                pend_commit <= !div_zero;
                cnt         <= CW'(DIV_CYCLES);
              end
              OP_MTHI: hi <= srcA;
              OP_MTLO: lo <= srcA;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1) && pend_commit) begin
            hi <= pend_hi;
            lo <= pend_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && is_md) next_state = BUSY;
      BUSY:    if (cnt == CW'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == BUSY);
    stall = hiloUseD && ((state == BUSY) || (start && is_md));
  end

endmodule
